// File: rtl/uart_tx_arbiter.sv
// Round-robin, frame-locked arbiter sharing one UART transmitter among NUM_REQ byte sources.
// Optional per-byte watchdog enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     byte_vld,
    input  logic [8*NUM_REQ-1:0]   byte_data,
    output logic [NUM_REQ-1:0]     byte_ack,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy,
    output logic                   frame_done,
    output logic [7:0]             tx_data,
    output logic                   start_tx,
    input  logic                   tx_idle,
    output logic                   timeout_err
);

    localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        WAIT_LO = 2'd2,
        WAIT_HI = 2'd3
    } state_t;

    state_t          state_r;
    logic [LW-1:0]   last_r;
    logic            win_found_s;
    logic [LW-1:0]   win_idx_s;
    logic [7:0]      lane_s;
    logic            wd_hit_s;

    // First set request after the previous winner, wrapping; last itself has lowest priority.
    function automatic logic [LW:0] rr_pick(input logic [NUM_REQ-1:0] r, input logic [LW-1:0] l);
        logic          found;
        logic [LW-1:0] w;
        logic [LW-1:0] pos;
        found = 1'b0;
        w     = l;
        for (int i = 1; i <= NUM_REQ; i++) begin
            pos = LW'((int'(l) + i) % NUM_REQ);
            if (!found && r[pos]) begin
                found = 1'b1;
                w     = pos;
            end else begin
                found = found;
            end
        end
        return {found, w};
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [LW-1:0] idx);
        return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Winner selection and owner lane extraction.
    always_comb begin
        {win_found_s, win_idx_s} = rr_pick(req, last_r);
    end

    assign lane_s = byte_data[{last_r, 3'b000} +: 8];

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wd_cnt_r;

    // Per-byte watchdog: cleared while loading, counts through both wait states.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wd_cnt_r <= {TW{1'b0}};
        end else if (state_r == LOAD) begin
            wd_cnt_r <= {TW{1'b0}};
        end else if (state_r == WAIT_LO || state_r == WAIT_HI) begin
            wd_cnt_r <= wd_cnt_r + {{(TW-1){1'b0}}, 1'b1};
        end else begin
            wd_cnt_r <= wd_cnt_r;
        end
    end

    assign wd_hit_s = (wd_cnt_r == TW'(TIMEOUT_CYCLES - 1));
`else
    assign wd_hit_s = 1'b0;
`endif

    // Arbitration and byte sequencing FSM; all outputs registered, pulses default low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= IDLE;
            last_r      <= LW'(NUM_REQ - 1);
            grant       <= {NUM_REQ{1'b0}};
            byte_ack    <= {NUM_REQ{1'b0}};
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            tx_data     <= 8'h00;
            start_tx    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            byte_ack    <= {NUM_REQ{1'b0}};
            frame_done  <= 1'b0;
            start_tx    <= 1'b0;
            timeout_err <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (win_found_s) begin
                        grant   <= onehot(win_idx_s);
                        last_r  <= win_idx_s;
                        busy    <= 1'b1;
                        state_r <= LOAD;
                    end
                end
                LOAD: begin
                    if (!req[last_r]) begin
                        grant      <= {NUM_REQ{1'b0}};
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        state_r    <= IDLE;
                    end else if (byte_vld[last_r] && tx_idle) begin
                        tx_data  <= lane_s;
                        start_tx <= 1'b1;
                        byte_ack <= onehot(last_r);
                        state_r  <= WAIT_LO;
                    end
                end
                WAIT_LO, WAIT_HI: begin
                    // A stuck UART abandons the frame silently: no frame_done.
                    if (wd_hit_s) begin
                        timeout_err <= 1'b1;
                        grant       <= {NUM_REQ{1'b0}};
                        busy        <= 1'b0;
                        state_r     <= IDLE;
                    end else if (state_r == WAIT_LO && !tx_idle) begin
                        state_r <= WAIT_HI;
                    end else if (state_r == WAIT_HI && tx_idle) begin
                        state_r <= LOAD;
                    end
                end
                default: begin
                    grant   <= {NUM_REQ{1'b0}};
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester models, a UART handshake model and monitors.
// Define UART_TX_ARB_TIMEOUT_EN to build the watchdog variant with TIMEOUT_CYCLES=100.
module tb_uart_tx_arbiter;

    localparam int N = 4;
`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int TO = 100;
`else
    localparam int TO = 200000;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   byte_vld = '0;
    logic [8*N-1:0] byte_data = '0;
    logic [N-1:0]   byte_ack;
    logic [N-1:0]   grant;
    logic           busy;
    logic           frame_done;
    logic [7:0]     tx_data;
    logic           start_tx;
    logic           tx_idle = 1'b1;
    logic           timeout_err;

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .byte_vld(byte_vld), .byte_data(byte_data),
        .byte_ack(byte_ack), .grant(grant), .busy(busy), .frame_done(frame_done),
        .tx_data(tx_data), .start_tx(start_tx), .tx_idle(tx_idle), .timeout_err(timeout_err)
    );

    initial forever #5 clk = ~clk;

    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0]   src_mem [N][4];
    int           src_len [N];
    int           ptr [N];
    bit [N-1:0]   src_en = '0;
    bit [N-1:0]   auto_drop = '0;
    int           fd_limit = 1000;
    int           st_cnt = 0, fd_cnt = 0, to_cnt = 0, gnt_n = 0, cyc = 0;
    int           st_cyc = 0, to_cyc = 0;
    int           ack_cnt [N];
    logic [7:0]   st_log [16];
    logic [N-1:0] gnt_log [16];
    logic [N-1:0] prev_grant = '0;
    logic [N-1:0] to_grant = '1;
    bit           multi_ack = 1'b0;
    int           uart_cnt = 0;
    int           uart_len = 20;
    bit           uart_stuck = 1'b0;

    // Monitors, requester byte sources and UART model, all updated away from the clock edge.
    initial begin
        for (int i = 0; i < N; i++) begin
            ptr[i] = 0; ack_cnt[i] = 0; src_len[i] = 0;
            for (int j = 0; j < 4; j++) src_mem[i][j] = 8'h00;
        end
        forever begin
            @(negedge clk);
            cyc++;
            if (start_tx === 1'b1) begin
                if (st_cnt < 16) st_log[st_cnt] = tx_data;
                st_cnt++;
                st_cyc = cyc;
            end
            if ($countones(byte_ack) > 1) multi_ack = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (byte_ack[i] === 1'b1) begin
                    ack_cnt[i]++;
                    ptr[i]++;
                    if (auto_drop[i]) req[i] = 1'b0;
                end
            end
            if (grant !== '0 && grant !== 'x && prev_grant === '0) begin
                if (gnt_n < 16) gnt_log[gnt_n] = grant;
                gnt_n++;
            end
            prev_grant = grant;
            if (timeout_err === 1'b1) begin
                to_cnt++;
                to_cyc = cyc;
                to_grant = grant;
            end
            if (frame_done === 1'b1) begin
                fd_cnt++;
                if (fd_cnt >= fd_limit) req = '0;
                else for (int i = 0; i < N; i++)
                    if (auto_drop[i] && !req[i]) begin req[i] = 1'b1; ptr[i] = 0; end
            end
            if (uart_cnt > 0) begin
                uart_cnt--;
                if (uart_cnt == 0) tx_idle = 1'b1;
            end else if (start_tx === 1'b1) begin
                tx_idle = 1'b0;
                if (!uart_stuck) uart_cnt = uart_len;
            end
            for (int i = 0; i < N; i++) begin
                byte_vld[i] = src_en[i] && (ptr[i] < src_len[i]);
                byte_data[8*i +: 8] = (ptr[i] < 4) ? src_mem[i][ptr[i]] : 8'h00;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr();
        st_cnt = 0; fd_cnt = 0; to_cnt = 0; gnt_n = 0;
        src_en = '0; auto_drop = '0; fd_limit = 1000;
        for (int i = 0; i < N; i++) begin ptr[i] = 0; ack_cnt[i] = 0; end
    endtask

    task automatic do_reset();
        rst = 1'b0; req = '0; clr(); uart_cnt = 0; tx_idle = 1'b1;
        tick(3);
        rst = 1'b1;
    endtask

    logic [N-1:0] exp_g [6];

    initial begin
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b1000;
        exp_g[3] = 4'b0001; exp_g[4] = 4'b0010; exp_g[5] = 4'b1000;

        // T1 reset
        rst = 1'b0; req = 4'b1111;
        tick(3);
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_outs", 32'({byte_ack, busy, frame_done, tx_data, start_tx, timeout_err}), 32'h0);
        rst = 1'b1;
        tick(1);
        check("rst_first_grant", 32'(grant), 32'h1);
        check("rst_first_busy", 32'(busy), 32'h1);
        req = '0;
        tick(1);
        check("t1_frame_done", 32'(frame_done), 32'h1);
        tick(1);
        check("t1_grant_clear", 32'(grant), 32'h0);

        // T2 single frame from requester 2
        clr();
        src_mem[2][0] = 8'h68; src_mem[2][1] = 8'h01; src_mem[2][2] = 8'h16;
        src_len[2] = 3; src_en[2] = 1'b1; req = 4'b0100;
        for (int k = 0; k < 400 && st_cnt < 3; k++) tick(1);
        tick(25);
        check("t2_start_cnt", 32'(st_cnt), 32'd3);
        check("t2_byte0", 32'(st_log[0]), 32'h68);
        check("t2_byte1", 32'(st_log[1]), 32'h01);
        check("t2_byte2", 32'(st_log[2]), 32'h16);
        check("t2_ack_cnt", 32'(ack_cnt[2]), 32'd3);
        check("t2_grant_held", 32'(grant), 32'h4);
        check("t2_no_fd_yet", 32'(fd_cnt), 32'd0);
        req = '0;
        tick(1);
        check("t2_frame_done", 32'(frame_done), 32'h1);
        check("t2_grant_clear", 32'(grant), 32'h0);
        check("t2_busy_clear", 32'(busy), 32'h0);

        // T3 round-robin with 1-byte frames from 0, 1, 3
        do_reset();
        for (int i = 0; i < N; i++) begin src_mem[i][0] = 8'(8'hA0 + i); src_len[i] = 1; end
        src_en = 4'b1011; auto_drop = 4'b1011; fd_limit = 6; req = 4'b1011;
        for (int k = 0; k < 2000 && fd_cnt < 6; k++) tick(1);
        tick(5);
        check("t3_frames", 32'(gnt_n), 32'd6);
        for (int i = 0; i < 6; i++) check($sformatf("t3_grant%0d", i), 32'(gnt_log[i]), 32'(exp_g[i]));
        check("t3_frame_done_cnt", 32'(fd_cnt), 32'd6);
        check("t3_start_cnt", 32'(st_cnt), 32'd6);
        check("t3_byte2", 32'(st_log[2]), 32'hA3);

        // T4 req dropped mid-byte
        clr();
        src_mem[1][0] = 8'h11; src_mem[1][1] = 8'h22; src_len[1] = 2; src_en[1] = 1'b1;
        req = 4'b0010;
        for (int k = 0; k < 100 && st_cnt < 1; k++) tick(1);
        tick(5);
        req = '0;
        for (int k = 0; k < 100 && !tx_idle; k++) @(posedge clk);
        @(negedge clk);
        check("t4_fd_not_early", 32'(frame_done), 32'h0);
        @(negedge clk);
        check("t4_frame_done", 32'(frame_done), 32'h1);
        check("t4_grant_clear", 32'(grant), 32'h0);
        tick(30);
        check("t4_start_cnt", 32'(st_cnt), 32'd1);
        check("t4_ack_cnt", 32'(ack_cnt[1]), 32'd1);

        // T5 owner stall, non-owner noise, UART busy on entry
        clr();
        for (int j = 0; j < 4; j++) src_mem[0][j] = 8'(8'hC0 + j);
        src_len[0] = 4; src_en[0] = 1'b1;
        src_mem[3][0] = 8'h5A; src_len[3] = 1;
        req = 4'b1000;
        tick(3);
        check("t5_grant", 32'(grant), 32'h8);
        for (int k = 0; k < 50; k++) begin
            req[0] = ((k / 5) % 2) == 1;
            tick(1);
        end
        req[0] = 1'b0;
        check("t5_no_start", 32'(st_cnt), 32'd0);
        check("t5_no_nonowner_ack", 32'(ack_cnt[0]), 32'd0);
        check("t5_grant_held", 32'(grant), 32'h8);
        tx_idle = 1'b0;
        src_en[3] = 1'b1;
        tick(10);
        check("t5_uart_busy_stall", 32'(st_cnt), 32'd0);
        tx_idle = 1'b1;
        for (int k = 0; k < 20 && st_cnt < 1; k++) tick(1);
        check("t5_byte", 32'(st_log[0]), 32'h5A);
        check("t5_ack", 32'(ack_cnt[3]), 32'd1);
        tick(25);
        req = '0;
        tick(3);

        // T6 UART stuck low
        clr();
        uart_stuck = 1'b1;
        src_mem[0][0] = 8'h77; src_len[0] = 1; src_en[0] = 1'b1;
        req = 4'b0001;
        for (int k = 0; k < 20 && st_cnt < 1; k++) tick(1);
        tick(150);
`ifdef UART_TX_ARB_TIMEOUT_EN
        check("t6_timeout_cnt", 32'(to_cnt), 32'd1);
        check("t6_timeout_delay", 32'(to_cyc - st_cyc), 32'd100);
        check("t6_timeout_grant", 32'(to_grant), 32'h0);
        check("t6_no_frame_done", 32'(fd_cnt), 32'd0);
`else
        tick(300);
        check("t6_grant_held", 32'(grant), 32'h1);
        check("t6_busy_held", 32'(busy), 32'h1);
        check("t6_no_timeout", 32'(to_cnt), 32'd0);
        check("t6_no_frame_done", 32'(fd_cnt), 32'd0);
`endif
        check("one_ack_per_cycle", 32'(multi_ack), 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
